ifu_miss_ctrl: RTL and testbench
================================

# ifu_miss_ctrl

Miss-handling controller for the IFU instruction cache. Accepts one line-fill request per cache miss and selects the target way: the first invalid way while the cache is not full, else the victim reported by the pseudo-LRU tree. It then fetches the line from memory beat by beat, writes the data words and tag into that way, and signals completion. It sits between the IFU lookup stage, the plru block, the cache data/tag arrays and the memory read port.

## Interface
- WAYS_NUM, 16, number of ways in the fully-associative cache; power of two, taken from ifu_pkg.
- LINE_WORDS, 4, 32-bit words per cache line; power of two, at least 2.
- ADDR_W, 32, byte address width.
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- miss_valid  in  1  lookup stage reports a miss.
- miss_addr  in  ADDR_W  byte address of the missing fetch.
- miss_ready  out  1  controller can accept a miss.
- valid_bits  in  WAYS_NUM  per-way valid bits from the tag array.
- plru_victim  in  clog2(WAYS_NUM)  victim way from plru (its evicted_cl output).
- plru_miss  out  1  one-cycle pulse to plru cache_miss when a way is selected.
- cache_full  out  1  AND of valid_bits; drives plru cache_full.
- mem_req_valid  out  1  line read request.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  ADDR_W  line-aligned address; low OFFSET_W bits are zero.
- mem_rsp_valid  in  1  one data beat is present.
- mem_rsp_data  in  32  beat data, delivered in ascending word order.
- fill_we  out  1  data-array write enable.
- fill_way  out  clog2(WAYS_NUM)  target way; also used for the tag write.
- fill_word  out  clog2(LINE_WORDS)  word index within the line.
- fill_data  out  32  write data.
- tag_we  out  1  tag-array write; sets the valid bit of fill_way.
- tag_value  out  TAG_W  equal to miss_addr[ADDR_W-1:OFFSET_W].
- fill_done  out  1  one-cycle pulse: line installed.
- busy  out  1  asserted in every state other than IDLE.

## Operation
- OFFSET_W = clog2(LINE_WORDS*4); TAG_W = ADDR_W - OFFSET_W.
- States: IDLE, VICTIM, REQ, FILL, COMMIT.
- IDLE: miss_ready=1. When miss_valid and miss_ready are both high, latch the line-aligned address and go to VICTIM. A miss that arrives while busy is not accepted; the requester holds it.
- VICTIM (1 cycle): if cache_full, register plru_victim as the way; else register the lowest-index way whose valid bit is 0. Pulse plru_miss. Go to REQ.
- REQ: hold mem_req_valid=1 with a stable mem_req_addr until mem_req_ready is high; on that cycle go to FILL. Clear the beat counter.
- FILL: each cycle with mem_rsp_valid high produces fill_we=1 combinationally, with fill_word=beat counter and fill_data=mem_rsp_data, then increments the counter. After the beat at index LINE_WORDS-1, go to COMMIT. Cycles without a beat leave the counter unchanged.
- COMMIT (1 cycle): tag_we=1 and fill_done=1 with the latched tag and way. Go to IDLE.
- mem_rsp_valid outside FILL is ignored; the bench flags it as a protocol error.
- Way selection uses the valid_bits sampled in the VICTIM cycle. Later changes to valid_bits do not affect the selected way.

## Timing
- Reset: state=IDLE, beat counter=0, latched address/way=0. miss_ready=1 from the first cycle after reset. All other control outputs are 0, and data outputs are 0.
- Reset mid-operation: returns to IDLE on the next edge and nothing is committed. Remaining beats of the aborted burst are ignored.
- Zero-wait memory: miss accepted at cycle T. VICTIM at T+1. mem_req_valid at T+2. Beats at T+3 through T+2+LINE_WORDS. fill_done at T+3+LINE_WORDS. miss_ready high again at T+4+LINE_WORDS.
- Each mem_req_ready stall or beat gap adds exactly one cycle.
- The counter never exceeds LINE_WORDS-1; no wrap occurs within a fill.

## Structure
- Add to ifu_pkg: the t_miss_state enum, LINE_WORDS, OFFSET_W and TAG_W. WAYS_NUM already lives there.
- One sub-module, ifu_first_free_way: a combinational priority encoder from valid_bits to the lowest free way index plus the full flag.

## Test plan
- Empty cache, miss at 0x0000_1234, zero-wait memory, beats A,B,C,D: fill_way=0; mem_req_addr=0x0000_1230; fill_word 0..3 carry A..D; fill_done at T+7; tag_value=0x0000123.
- valid_bits=0xFFF7: way 3 selected; plru_miss pulses; plru_victim is ignored.
- valid_bits=0xFFFF, plru_victim=9: cache_full=1; fill_way=9.
- mem_req_ready held low for 3 cycles and a 2-cycle gap between beats 1 and 2: address stable throughout; fill_done at T+12.
- rst asserted after beat 1: no tag_we and no fill_done; IDLE on the next cycle. A following miss is handled normally.
- miss_valid held high during a fill: miss_ready=0 until the cycle after fill_done; then the second miss is accepted.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared IFU definitions: cache geometry, miss-controller state encoding and
// line-address helpers.
package ifu_pkg;

    localparam int WAYS_NUM   = 16;
    localparam int WAY_W      = $clog2(WAYS_NUM);
    localparam int LINE_WORDS = 4;
    localparam int WORD_IDX_W = $clog2(LINE_WORDS);
    localparam int ADDR_W     = 32;
    localparam int OFFSET_W   = $clog2(LINE_WORDS * 4);
    localparam int TAG_W      = ADDR_W - OFFSET_W;

    localparam logic [ADDR_W-1:0] LINE_MASK = {{TAG_W{1'b1}}, {OFFSET_W{1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VICTIM = 3'd1,
        ST_REQ    = 3'd2,
        ST_FILL   = 3'd3,
        ST_COMMIT = 3'd4
    } t_miss_state;

    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
        return addr & LINE_MASK;
    endfunction

endpackage

// File: rtl/ifu_first_free_way.sv
// Lowest-index invalid way of the fully-associative cache, plus the all-valid
// flag that tells the miss controller to fall back to the plru victim.
module ifu_first_free_way
    import ifu_pkg::*;
(
    input  logic [WAYS_NUM-1:0] valid_bits,
    output logic [WAY_W-1:0]    free_way,
    output logic                all_valid
);

    // Scan from the top so the lowest invalid way is the last one written.
    always_comb begin
        free_way = '0;
        for (int i = WAYS_NUM - 1; i >= 0; i--) begin
            if (!valid_bits[i]) begin
                free_way = WAY_W'(i);
            end else begin
                free_way = free_way;
            end
        end
    end

    assign all_valid = &valid_bits;

endmodule

// File: rtl/ifu_miss_ctrl.sv
// IFU instruction-cache miss controller: picks a way, reads the line from
// memory beat by beat, writes data then tag, and pulses fill_done.
module ifu_miss_ctrl
    import ifu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_valid,
    input  logic [ADDR_W-1:0]     miss_addr,
    output logic                  miss_ready,
    input  logic [WAYS_NUM-1:0]   valid_bits,
    input  logic [WAY_W-1:0]      plru_victim,
    output logic                  plru_miss,
    output logic                  cache_full,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_req_addr,
    input  logic                  mem_rsp_valid,
    input  logic [31:0]           mem_rsp_data,
    output logic                  fill_we,
    output logic [WAY_W-1:0]      fill_way,
    output logic [WORD_IDX_W-1:0] fill_word,
    output logic [31:0]           fill_data,
    output logic                  tag_we,
    output logic [TAG_W-1:0]      tag_value,
    output logic                  fill_done,
    output logic                  busy
);

    t_miss_state           state_r;
    logic [ADDR_W-1:0]     addr_r;
    logic [WAY_W-1:0]      way_r;
    logic [WORD_IDX_W-1:0] beat_r;
    logic [WAY_W-1:0]      free_way_s;
    logic                  all_valid_s;
    logic                  beat_s;
    logic                  last_beat_s;

    ifu_first_free_way u_first_free_way (
        .valid_bits (valid_bits),
        .free_way   (free_way_s),
        .all_valid  (all_valid_s)
    );

    assign cache_full  = all_valid_s;
    assign beat_s      = (state_r == ST_FILL) && mem_rsp_valid;
    assign last_beat_s = (beat_r == WORD_IDX_W'(LINE_WORDS - 1));

    // Miss FSM with the latched line address, chosen way and beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            addr_r  <= '0;
            way_r   <= '0;
            beat_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (miss_valid) begin
                        addr_r  <= line_align(miss_addr);
                        state_r <= ST_VICTIM;
                    end
                end
                ST_VICTIM: begin
                    // valid_bits is only looked at here; later changes cannot move the way.
                    way_r   <= all_valid_s ? plru_victim : free_way_s;
                    state_r <= ST_REQ;
                end
                ST_REQ: begin
                    beat_r <= '0;
                    if (mem_req_ready) begin
                        state_r <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (mem_rsp_valid) begin
                        if (last_beat_s) begin
                            beat_r  <= '0;
                            state_r <= ST_COMMIT;
                        end else begin
                            beat_r <= beat_r + WORD_IDX_W'(1);
                        end
                    end
                end
                ST_COMMIT: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake and strobe decode from the state register.
    always_comb begin
        miss_ready    = 1'b0;
        plru_miss     = 1'b0;
        mem_req_valid = 1'b0;
        tag_we        = 1'b0;
        fill_done     = 1'b0;
        case (state_r)
            ST_IDLE:   miss_ready    = 1'b1;
            ST_VICTIM: plru_miss     = 1'b1;
            ST_REQ:    mem_req_valid = 1'b1;
            ST_COMMIT: begin
                tag_we    = 1'b1;
                fill_done = 1'b1;
            end
            default: begin
                miss_ready = 1'b0;
            end
        endcase
    end

    // Beats are written straight through; the data bus idles at zero.
    always_comb begin
        fill_data = '0;
        if (beat_s) begin
            fill_data = mem_rsp_data;
        end else begin
            fill_data = '0;
        end
    end

    assign busy         = (state_r != ST_IDLE);
    assign fill_we      = beat_s;
    assign fill_way     = way_r;
    assign fill_word    = beat_r;
    assign mem_req_addr = addr_r;
    assign tag_value    = addr_r[ADDR_W-1:OFFSET_W];

endmodule

// File: tb/tb_ifu_miss_ctrl.sv
// Self-checking bench for ifu_miss_ctrl: directed scenarios plus randomized
// fills compared against a line-fill reference model.
module tb_ifu_miss_ctrl;
    import ifu_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  miss_valid;
    logic [ADDR_W-1:0]     miss_addr;
    logic                  miss_ready;
    logic [WAYS_NUM-1:0]   valid_bits;
    logic [WAY_W-1:0]      plru_victim;
    logic                  plru_miss;
    logic                  cache_full;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_W-1:0]     mem_req_addr;
    logic                  mem_rsp_valid;
    logic [31:0]           mem_rsp_data;
    logic                  fill_we;
    logic [WAY_W-1:0]      fill_way;
    logic [WORD_IDX_W-1:0] fill_word;
    logic [31:0]           fill_data;
    logic                  tag_we;
    logic [TAG_W-1:0]      tag_value;
    logic                  fill_done;
    logic                  busy;

    ifu_miss_ctrl dut (
        .clk(clk), .rst(rst), .miss_valid(miss_valid), .miss_addr(miss_addr),
        .miss_ready(miss_ready), .valid_bits(valid_bits), .plru_victim(plru_victim),
        .plru_miss(plru_miss), .cache_full(cache_full), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .fill_we(fill_we),
        .fill_way(fill_way), .fill_word(fill_word), .fill_data(fill_data),
        .tag_we(tag_we), .tag_value(tag_value), .fill_done(fill_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Memory beats served for the current fill.
    logic [31:0] beat_data [LINE_WORDS];

    // Observations gathered by the fill driver (cycle numbers relative to acceptance).
    int                    obs_n, obs_done_c, obs_tagwe_c, obs_plru_n, obs_plru_c;
    int                    obs_req_n, obs_ready_busy, obs_commit_n;
    logic                  obs_accept_ready, obs_full, obs_req_stable, obs_ready_after;
    logic                  obs_busy_after_rst, obs_ready_after_rst;
    logic [ADDR_W-1:0]     obs_req_addr;
    logic [TAG_W-1:0]      obs_tag;
    logic [WAY_W-1:0]      obs_commit_way;
    logic [WORD_IDX_W-1:0] obs_word [8];
    logic [31:0]           obs_data [8];
    logic [WAY_W-1:0]      obs_way  [8];

    // Reference: an invalid way wins (lowest index), else the plru victim.
    function automatic logic [WAY_W-1:0] ref_way(input logic [WAYS_NUM-1:0] vb,
                                                 input logic [WAY_W-1:0] vic);
        logic [WAYS_NUM-1:0] free_m, lowest;
        if (&vb) return vic;
        free_m = ~vb;
        lowest = free_m & (~free_m + 1'b1);
        return WAY_W'($clog2(lowest));
    endfunction

    function automatic int ref_done(input int stall, input int gap_len);
        return 3 + LINE_WORDS + stall + gap_len;
    endfunction

    // Presents one miss, acts as the memory, and records what the DUT does.
    // Entered and left mid-cycle (#1 after a rising edge).
    task automatic do_fill(input logic [ADDR_W-1:0] addr, input logic [WAYS_NUM-1:0] vb,
                           input logic [WAY_W-1:0] vic, input int stall, input int gap_beat,
                           input int gap_len, input int abort_after, input bit hold_miss,
                           input logic [ADDR_W-1:0] next_addr, input bit churn_valid);
        int beat, gap_left, req_cnt, stop_c, abort_c;
        bit phase, aborted;
        obs_n = 0; obs_done_c = -1; obs_tagwe_c = -1; obs_plru_n = 0; obs_plru_c = -1;
        obs_req_n = 0; obs_ready_busy = 0; obs_commit_n = 0; obs_req_stable = 1'b1;
        obs_ready_after = 1'b0; obs_busy_after_rst = 1'b1; obs_ready_after_rst = 1'b0;
        obs_req_addr = '0; obs_tag = '0; obs_commit_way = '0; obs_full = 1'b0;
        miss_valid = 1'b1; miss_addr = addr; valid_bits = vb; plru_victim = vic;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        #1;
        obs_accept_ready = miss_ready;
        beat = 0; gap_left = gap_len; req_cnt = 0; stop_c = 60; phase = 1'b0;
        aborted = 1'b0; abort_c = -10;
        for (int c = 1; c <= stop_c; c++) begin
            @(posedge clk); #1;
            rst = 1'b0;
            miss_valid = hold_miss;
            miss_addr = hold_miss ? next_addr : addr;
            if (churn_valid && c >= 2) valid_bits = WAYS_NUM'($urandom);
            mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = $urandom;
            if (abort_after >= 0 && !aborted && beat == abort_after + 1) begin
                rst = 1'b1; aborted = 1'b1; abort_c = c;
            end else if (phase && beat < LINE_WORDS) begin
                if (beat == gap_beat && gap_left > 0) begin
                    gap_left--;
                end else begin
                    mem_rsp_valid = 1'b1; mem_rsp_data = beat_data[beat]; beat++;
                end
            end
            if (!phase && mem_req_valid) begin
                if (req_cnt == 0) obs_req_addr = mem_req_addr;
                else if (mem_req_addr !== obs_req_addr) obs_req_stable = 1'b0;
                mem_req_ready = (req_cnt == stall);
                req_cnt++;
                if (mem_req_ready) phase = 1'b1;
            end
            #1;
            if (mem_req_valid) obs_req_n++;
            if (fill_we) begin
                if (obs_n < 8) begin
                    obs_word[obs_n] = fill_word; obs_data[obs_n] = fill_data;
                    obs_way[obs_n] = fill_way;
                end
                obs_n++;
            end
            if (plru_miss) begin obs_plru_n++; obs_plru_c = c; end
            if (c == 1) obs_full = cache_full;
            if (tag_we) obs_tagwe_c = c;
            if (fill_done) begin
                obs_done_c = c; obs_tag = tag_value; obs_commit_way = fill_way; obs_commit_n++;
            end else if (obs_done_c < 0 && miss_ready && !aborted) begin
                obs_ready_busy++;
            end
            if (aborted && c == abort_c + 1) begin
                obs_busy_after_rst = busy; obs_ready_after_rst = miss_ready;
            end
            if (obs_done_c >= 0 && c == obs_done_c + 1) begin
                obs_ready_after = miss_ready; stop_c = c;
            end
            if (aborted && c == abort_c + LINE_WORDS + 2) stop_c = c;
        end
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; miss_valid = 1'b0; miss_addr = '0; valid_bits = '0; plru_victim = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0; #1;
        n_tests++; if (miss_ready !== 1'b1 || busy !== 1'b0) begin n_fail++;
            $display("FAIL reset_status: ready/busy=%b%b expected 10", miss_ready, busy); end
        n_tests++; if ({mem_req_valid, fill_we, tag_we, fill_done, plru_miss} !== 5'b0) begin n_fail++;
            $display("FAIL reset_ctrl: %b expected 00000",
                     {mem_req_valid, fill_we, tag_we, fill_done, plru_miss}); end
        n_tests++; if (mem_req_addr !== '0 || tag_value !== '0 || fill_way !== '0 ||
                       fill_word !== '0 || fill_data !== '0) begin n_fail++;
            $display("FAIL reset_data: addr=%h tag=%h way=%0d word=%0d data=%h expected all 0",
                     mem_req_addr, tag_value, fill_way, fill_word, fill_data); end
    endtask

    task automatic test_empty_fill();
        beat_data[0] = 32'hAAAA_0000; beat_data[1] = 32'hBBBB_1111;
        beat_data[2] = 32'hCCCC_2222; beat_data[3] = 32'hDDDD_3333;
        do_fill(32'h0000_1234, '0, WAY_W'(5), 0, -1, 0, -1, 1'b0, '0, 1'b0);
        n_tests++; if (obs_accept_ready !== 1'b1) begin n_fail++;
            $display("FAIL empty_accept: miss_ready=%b expected 1", obs_accept_ready); end
        n_tests++; if (obs_req_addr !== 32'h0000_1230) begin n_fail++;
            $display("FAIL empty_req_addr: %h expected 00001230", obs_req_addr); end
        n_tests++; if (obs_n !== LINE_WORDS) begin n_fail++;
            $display("FAIL empty_beats: %0d writes expected %0d", obs_n, LINE_WORDS); end
        for (int i = 0; i < LINE_WORDS; i++) begin
            n_tests++;
            if (obs_word[i] !== WORD_IDX_W'(i) || obs_data[i] !== beat_data[i] ||
                obs_way[i] !== WAY_W'(0)) begin n_fail++;
                $display("FAIL empty_word%0d: word=%0d data=%h way=%0d expected %0d %h 0",
                         i, obs_word[i], obs_data[i], obs_way[i], i, beat_data[i]); end
        end
        n_tests++; if (obs_done_c !== 7 || obs_tagwe_c !== 7) begin n_fail++;
            $display("FAIL empty_done_cycle: done=%0d tag_we=%0d expected 7 7",
                     obs_done_c, obs_tagwe_c); end
        n_tests++; if (obs_tag !== TAG_W'(28'h000_0123) || obs_commit_way !== WAY_W'(0)) begin
            n_fail++; $display("FAIL empty_tag: tag=%h way=%0d expected 0000123 0",
                               obs_tag, obs_commit_way); end
        n_tests++; if (obs_ready_after !== 1'b1) begin n_fail++;
            $display("FAIL empty_ready_after: %b expected 1", obs_ready_after); end
    endtask

    task automatic test_partial_valid();
        for (int i = 0; i < LINE_WORDS; i++) beat_data[i] = $urandom;
        do_fill(32'h0040_0000, 16'hFFF7, WAY_W'(12), 0, -1, 0, -1, 1'b0, '0, 1'b0);
        n_tests++; if (obs_plru_n !== 1 || obs_plru_c !== 1) begin n_fail++;
            $display("FAIL partial_plru_miss: pulses=%0d at %0d expected 1 at 1",
                     obs_plru_n, obs_plru_c); end
        n_tests++; if (obs_full !== 1'b0 || obs_commit_way !== WAY_W'(3)) begin n_fail++;
            $display("FAIL partial_way: full=%b way=%0d expected 0 3", obs_full, obs_commit_way); end
    endtask

    task automatic test_full_victim();
        for (int i = 0; i < LINE_WORDS; i++) beat_data[i] = $urandom;
        do_fill(32'h8000_0FFC, 16'hFFFF, WAY_W'(9), 0, -1, 0, -1, 1'b0, '0, 1'b0);
        n_tests++; if (obs_full !== 1'b1 || obs_commit_way !== WAY_W'(9) || obs_way[0] !== WAY_W'(9))
        begin n_fail++;
            $display("FAIL full_victim: full=%b way=%0d beat_way=%0d expected 1 9 9",
                     obs_full, obs_commit_way, obs_way[0]); end
    endtask

    task automatic test_stalls();
        for (int i = 0; i < LINE_WORDS; i++) beat_data[i] = $urandom;
        do_fill(32'h1234_5678, 16'h00FF, WAY_W'(0), 3, 2, 2, -1, 1'b0, '0, 1'b0);
        n_tests++; if (obs_req_stable !== 1'b1 || obs_req_n !== 4 ||
                       obs_req_addr !== 32'h1234_5670) begin n_fail++;
            $display("FAIL stall_req: stable=%b cycles=%0d addr=%h expected 1 4 12345670",
                     obs_req_stable, obs_req_n, obs_req_addr); end
        n_tests++; if (obs_done_c !== 12) begin n_fail++;
            $display("FAIL stall_done_cycle: %0d expected 12", obs_done_c); end
        n_tests++; if (obs_n !== LINE_WORDS || obs_data[2] !== beat_data[2] ||
                       obs_word[3] !== WORD_IDX_W'(3)) begin n_fail++;
            $display("FAIL stall_beats: n=%0d data2=%h word3=%0d expected %0d %h 3",
                     obs_n, obs_data[2], obs_word[3], LINE_WORDS, beat_data[2]); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < LINE_WORDS; i++) beat_data[i] = $urandom;
        do_fill(32'h0000_2000, 16'h0001, WAY_W'(0), 0, -1, 0, 1, 1'b0, '0, 1'b0);
        n_tests++; if (obs_commit_n !== 0 || obs_tagwe_c !== -1 || obs_n !== 2) begin n_fail++;
            $display("FAIL abort_commit: fill_done=%0d tag_we_at=%0d writes=%0d expected 0 -1 2",
                     obs_commit_n, obs_tagwe_c, obs_n); end
        n_tests++; if (obs_busy_after_rst !== 1'b0 || obs_ready_after_rst !== 1'b1) begin n_fail++;
            $display("FAIL abort_idle: busy=%b ready=%b expected 0 1",
                     obs_busy_after_rst, obs_ready_after_rst); end
        for (int i = 0; i < LINE_WORDS; i++) beat_data[i] = $urandom;
        do_fill(32'h0000_3008, 16'h0003, WAY_W'(0), 0, -1, 0, -1, 1'b0, '0, 1'b0);
        n_tests++; if (obs_done_c !== 7 || obs_commit_way !== WAY_W'(2) ||
                       obs_tag !== TAG_W'(28'h000_0300)) begin n_fail++;
            $display("FAIL abort_next_fill: done=%0d way=%0d tag=%h expected 7 2 0000300",
                     obs_done_c, obs_commit_way, obs_tag); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < LINE_WORDS; i++) beat_data[i] = $urandom;
        do_fill(32'h0000_4010, 16'h0000, WAY_W'(0), 0, -1, 0, -1, 1'b1, 32'h0000_5020, 1'b0);
        n_tests++; if (obs_ready_busy !== 0 || obs_ready_after !== 1'b1 || obs_done_c !== 7) begin
            n_fail++; $display("FAIL b2b_hold: ready_while_busy=%0d ready_after=%b done=%0d expected 0 1 7",
                               obs_ready_busy, obs_ready_after, obs_done_c); end
        for (int i = 0; i < LINE_WORDS; i++) beat_data[i] = $urandom;
        do_fill(32'h0000_5020, 16'h0000, WAY_W'(0), 0, -1, 0, -1, 1'b0, '0, 1'b0);
        n_tests++; if (obs_done_c !== 7 || obs_tag !== TAG_W'(28'h000_0502) ||
                       obs_req_addr !== 32'h0000_5020) begin n_fail++;
            $display("FAIL b2b_second: done=%0d tag=%h addr=%h expected 7 0000502 00005020",
                     obs_done_c, obs_tag, obs_req_addr); end
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0]   a;
        logic [WAYS_NUM-1:0] vb;
        logic [WAY_W-1:0]    vic;
        int stall, gbeat, glen, bad;
        for (int it = 0; it < 20; it++) begin
            a = $urandom; vic = WAY_W'($urandom);
            vb = ($urandom_range(0, 2) == 0) ? '1 : WAYS_NUM'($urandom);
            stall = $urandom_range(0, 3); gbeat = $urandom_range(0, LINE_WORDS - 1);
            glen = $urandom_range(0, 2);
            for (int i = 0; i < LINE_WORDS; i++) beat_data[i] = $urandom;
            do_fill(a, vb, vic, stall, gbeat, glen, -1, 1'b0, '0, 1'b1);
            bad = 0;
            for (int i = 0; i < LINE_WORDS; i++)
                if (obs_word[i] !== WORD_IDX_W'(i) || obs_data[i] !== beat_data[i] ||
                    obs_way[i] !== ref_way(vb, vic)) bad++;
            n_tests++; if (obs_n !== LINE_WORDS || bad != 0) begin n_fail++;
                $display("FAIL rand%0d_beats: writes=%0d bad=%0d expected %0d 0 (vb=%h vic=%0d)",
                         it, obs_n, bad, LINE_WORDS, vb, vic); end
            n_tests++; if (obs_commit_way !== ref_way(vb, vic) || obs_full !== (&vb)) begin n_fail++;
                $display("FAIL rand%0d_way: way=%0d full=%b expected %0d %b",
                         it, obs_commit_way, obs_full, ref_way(vb, vic), &vb); end
            n_tests++; if (obs_req_addr !== ((a >> OFFSET_W) << OFFSET_W) || !obs_req_stable ||
                           obs_tag !== TAG_W'(a >> OFFSET_W)) begin n_fail++;
                $display("FAIL rand%0d_addr: req=%h tag=%h stable=%b for miss %h",
                         it, obs_req_addr, obs_tag, obs_req_stable, a); end
            n_tests++; if (obs_done_c !== ref_done(stall, glen) || obs_plru_n !== 1) begin n_fail++;
                $display("FAIL rand%0d_timing: done=%0d plru=%0d expected %0d 1",
                         it, obs_done_c, obs_plru_n, ref_done(stall, glen)); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_empty_fill();
        test_partial_valid();
        test_full_victim();
        test_stalls();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
